// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchroniser plus debounce FSM giving a clean level and press/release/long strobes.
// Optional macro KEY_REPEAT_EN builds the auto-repeat counter that re-pulses key_long during a hold.
module key_debounce #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_PRESS_MS  = 1000,
  parameter int REPEAT_MS      = 200,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic sys_clk50m,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CYC_PER_MS = CLK_FREQ / 1000;
  localparam int DB_CYC     = CYC_PER_MS * DEBOUNCE_MS;
  localparam int LONG_CYC   = CYC_PER_MS * LONG_PRESS_MS;
  localparam int DB_W       = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int HOLD_W     = $clog2(LONG_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic              IDLE_PIN  = KEY_ACTIVE_LOW;

  if (!((LONG_PRESS_MS > DEBOUNCE_MS) && (DEBOUNCE_MS >= 1) && (REPEAT_MS >= 1))) begin : g_param_check
    $error("key_debounce: need LONG_PRESS_MS > DEBOUNCE_MS >= 1 and REPEAT_MS >= 1");
  end

  logic r_sync1;
  logic r_sync2;
  logic w_pressed;

  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1 <= IDLE_PIN;
      r_sync2 <= IDLE_PIN;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  state_t              r_state;
  logic [DB_W-1:0]     r_dbCnt;
  logic [HOLD_W-1:0]   r_holdCnt;

`ifdef KEY_REPEAT_EN
  localparam int RPT_CYC = CYC_PER_MS * REPEAT_MS;
  localparam int RPT_W   = (RPT_CYC > 1) ? $clog2(RPT_CYC) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_CYC - 1);

  logic [RPT_W-1:0] r_rptCnt;
`endif

  // key_long fires on the edge where hold_cnt steps from LONG_CYC-1 to its saturation value,
  // so it can only happen once per hold; bounce in RELEASE_DB leaves hold_cnt untouched.
  always_ff @(posedge sys_clk50m or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= IDLE;
      r_dbCnt     <= '0;
      r_holdCnt   <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rptCnt    <= '0;
`endif
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pressed) begin
            r_state <= PRESS_DB;
            r_dbCnt <= '0;
          end
        end
        PRESS_DB: begin
          if (!w_pressed) begin
            r_state <= IDLE;
            r_dbCnt <= '0;
          end else if (r_dbCnt == DB_LAST) begin
            r_state   <= HELD;
            r_dbCnt   <= '0;
            r_holdCnt <= '0;
            key_press <= 1'b1;
            key_level <= 1'b1;
`ifdef KEY_REPEAT_EN
            r_rptCnt  <= '0;
`endif
          end else begin
            r_dbCnt <= r_dbCnt + 1'b1;
          end
        end
        HELD: begin
          if (r_holdCnt != HOLD_MAX) begin
            r_holdCnt <= r_holdCnt + 1'b1;
          end
          if (r_holdCnt == HOLD_LAST) begin
            key_long <= 1'b1;
          end
`ifdef KEY_REPEAT_EN
          // Repeat period runs only after the first long strobe has saturated hold_cnt.
          else if (r_holdCnt == HOLD_MAX) begin
            if (r_rptCnt == RPT_LAST) begin
              r_rptCnt <= '0;
              key_long <= 1'b1;
            end else begin
              r_rptCnt <= r_rptCnt + 1'b1;
            end
          end
`endif
          if (!w_pressed) begin
            r_state <= RELEASE_DB;
            r_dbCnt <= '0;
          end
        end
        RELEASE_DB: begin
          if (w_pressed) begin
            r_state <= HELD;
            r_dbCnt <= '0;
          end else if (r_dbCnt == DB_LAST) begin
            r_state     <= IDLE;
            r_dbCnt     <= '0;
            key_release <= 1'b1;
            key_level   <= 1'b0;
          end else begin
            r_dbCnt <= r_dbCnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dbCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: drives an active-low and an active-high key_debounce side by side with mirrored pins
// and compares {level, press, release, long} every cycle against hand-derived expectations.
module tb_key_debounce;

  // Expected-output encoding used throughout: {level, press, release, long}
  localparam logic [3:0] E_IDLE = 4'b0000;
  localparam logic [3:0] E_PRESS = 4'b1100;
  localparam logic [3:0] E_HELD = 4'b1000;
  localparam logic [3:0] E_RELEASE = 4'b0010;
  localparam logic [3:0] E_LONG = 4'b1001;

`ifdef KEY_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk;
  logic sysRst;
  logic keyLo;
  logic keyHi;
  logic levelLo, pressLo, releaseLo, longLo;
  logic levelHi, pressHi, releaseHi, longHi;

  int checks;
  int fails;

  typedef struct {
    logic       pin;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  key_debounce #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .LONG_PRESS_MS(20), .REPEAT_MS(5), .KEY_ACTIVE_LOW(1'b1)
  ) dutLow (
    .sys_clk50m(clk), .sys_rst(sysRst), .key_in(keyLo),
    .key_level(levelLo), .key_press(pressLo), .key_release(releaseLo), .key_long(longLo)
  );

  key_debounce #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(4), .LONG_PRESS_MS(20), .REPEAT_MS(5), .KEY_ACTIVE_LOW(1'b0)
  ) dutHigh (
    .sys_clk50m(clk), .sys_rst(sysRst), .key_in(keyHi),
    .key_level(levelHi), .key_press(pressHi), .key_release(releaseHi), .key_long(longHi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pinLo is the active-low pin value; the active-high DUT gets its mirror image
  task automatic applyStimulus(input logic pinLo);
    keyLo = pinLo;
    keyHi = ~pinLo;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [3:0] exp);
    logic [3:0] gotLo;
    logic [3:0] gotHi;
    gotLo = {levelLo, pressLo, releaseLo, longLo};
    gotHi = {levelHi, pressHi, releaseHi, longHi};
    checks++;
    if (gotLo !== exp) begin
      fails++;
      $display("[TB] FAIL %s[%0d] active-low dut: got %b required %b", name, idx, gotLo, exp);
    end
    checks++;
    if (gotHi !== exp) begin
      fails++;
      $display("[TB] FAIL %s[%0d] active-high dut: got %b required %b", name, idx, gotHi, exp);
    end
  endtask

  function automatic void addVec(input logic pin, input logic [3:0] exp);
    vec_t v;
    v.pin = pin;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [3:0] exp;
    logic pin;
    checks = 0;
    fails  = 0;
    sysRst = 1'b1;
    keyLo  = 1'b1;
    keyHi  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 0, E_IDLE);
    sysRst = 1'b0;

    // Table: quiet after reset, a 3-cycle glitch, then a clean press held a few cycles
    for (int i = 0; i < 3; i++) addVec(1'b1, E_IDLE);
    for (int i = 0; i < 3; i++) addVec(1'b0, E_IDLE);
    for (int i = 0; i < 8; i++) addVec(1'b1, E_IDLE);
    for (int i = 0; i < 6; i++) addVec(1'b0, E_IDLE);
    addVec(1'b0, E_PRESS);
    for (int i = 0; i < 3; i++) addVec(1'b0, E_HELD);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].pin);
      checkOutput("table", i, vecs[i].exp);
    end

    // Bouncy release: pin toggles 1,0,1,0,1,0,1 then stays released; release 7 edges after last toggle
    for (int e = 1; e <= 16; e++) begin
      pin = (e <= 7) ? ((e % 2) == 1) : 1'b1;
      if (e < 13) exp = E_HELD;
      else if (e == 13) exp = E_RELEASE;
      else exp = E_IDLE;
      applyStimulus(pin);
      checkOutput("bouncy_release", e, exp);
    end

    // Long hold: pressed for 40 records, then released
    for (int e = 1; e <= 50; e++) begin
      pin = (e <= 40) ? 1'b0 : 1'b1;
      if (e < 7) exp = E_IDLE;
      else if (e == 7) exp = E_PRESS;
      else if (e == 27) exp = E_LONG;
      else if (REPEAT_ON && e > 27 && e <= 43 && ((e - 27) % 5) == 0) exp = E_LONG;
      else if (e < 47) exp = E_HELD;
      else if (e == 47) exp = E_RELEASE;
      else exp = E_IDLE;
      applyStimulus(pin);
      checkOutput("long_hold", e, exp);
    end

    // Reset mid-hold with the key still pressed
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1'b0);
      checkOutput("pre_reset_press", e, (e < 7) ? E_IDLE : ((e == 7) ? E_PRESS : E_HELD));
    end
    sysRst = 1'b1;
    #1;
    checkOutput("async_reset", 0, E_IDLE);
    for (int e = 1; e <= 2; e++) begin
      applyStimulus(1'b0);
      checkOutput("in_reset", e, E_IDLE);
    end
    sysRst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(1'b0);
      checkOutput("post_reset_press", e, (e < 7) ? E_IDLE : ((e == 7) ? E_PRESS : E_HELD));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
